// File: rtl/daq_pkg.sv
// Shared widths, sample type and helpers for the LPDAQ sample buffer.
package daq_pkg;
    localparam int DAQ_SAMPLE_W = 24;
    localparam int DAQ_RDCNT_W  = 32;
    localparam int DAQ_OVF_W    = 16;

    typedef logic signed [DAQ_SAMPLE_W-1:0] daq_sample_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DAQ_OVF_W-1:0] ovf_sat_inc(input logic [DAQ_OVF_W-1:0] v);
        return (v == '1) ? v : v + DAQ_OVF_W'(1);
    endfunction
endpackage

// File: rtl/daq_fifo_mem.sv
// Single-write-port register array with asynchronous read, backing the sample FIFO.
module daq_fifo_mem
    import daq_pkg::*;
#(
    parameter int DW         = DAQ_SAMPLE_W,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DW-1:0]         rd_data
);
    logic [DW-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset; validity is tracked by the count, so a
    // reset here would only add a large fan-out with no functional benefit.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/daq_sample_fifo.sv
// FWFT sample buffer: AXI-stream in/out, registered occupancy, level IRQ and drop accounting.
module daq_sample_fifo
    import daq_pkg::*;
#(
    parameter int DW           = DAQ_SAMPLE_W,
    parameter int DEPTH_LOG2   = 8,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DW-1:0]          m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DAQ_RDCNT_W-1:0] rd_cnt,
    input  logic [DEPTH_LOG2:0]    thresh,
    output logic                   level_irq,
    input  logic                   flush,
    input  logic                   clr_ovf,
    output logic [DAQ_OVF_W-1:0]   overflow_cnt,
    output logic                   ovf_sticky
);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count, count_next;
    logic                  full, pop, push, accept, drop, s_ready_q;

    assign full          = (count == FULL_CNT);
    assign m_axis_tvalid = (count != '0);
    assign s_axis_tready = s_ready_q;

    // Flush outranks both handshakes, so neither side takes effect under it.
    assign pop    = m_axis_tvalid & m_axis_tready & ~flush;
    assign accept = DROP_ON_FULL ? (~full | pop) : s_ready_q;
    assign push   = s_axis_tvalid & accept & ~flush;
    assign drop   = DROP_ON_FULL & s_axis_tvalid & full & ~pop & ~flush;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_next = count;
        if (flush)              count_next = '0;
        else if (push && !pop)  count_next = count + 1'b1;
        else if (pop && !push)  count_next = count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_cnt    <= '0;
            level_irq <= 1'b0;
            s_ready_q <= DROP_ON_FULL;
        end else begin
            count     <= count_next;
            rd_cnt    <= DAQ_RDCNT_W'(count_next);
            level_irq <= (thresh != '0) && (count_next >= thresh);
            s_ready_q <= DROP_ON_FULL | (count_next != FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A drop coinciding with clr_ovf must survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
            ovf_sticky   <= 1'b0;
        end else if (clr_ovf) begin
            overflow_cnt <= drop ? DAQ_OVF_W'(1) : '0;
            ovf_sticky   <= drop;
        end else if (drop) begin
            overflow_cnt <= ovf_sat_inc(overflow_cnt);
            ovf_sticky   <= 1'b1;
        end
    end

    daq_fifo_mem #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr),
        .rd_data (m_axis_tdata)
    );
endmodule

// File: tb/tb_daq_sample_fifo.sv
// Scoreboard bench for daq_sample_fifo at depth 4, one drop-mode and one stall-mode instance.
module tb_daq_sample_fifo;
    import daq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tready, m_tvalid, m_tready = 1'b0;
    logic [23:0] m_tdata;
    logic [31:0] rd_cnt;
    logic [2:0]  thresh = '0;
    logic        level_irq, flush = 1'b0, clr_ovf = 1'b0, ovf_sticky;
    logic [15:0] ovf_cnt;

    logic [23:0] s_tdata2 = '0;
    logic        s_tvalid2 = 1'b0, s_tready2, m_tvalid2, m_tready2 = 1'b0;
    logic [23:0] m_tdata2;
    logic [31:0] rd_cnt2;
    logic [2:0]  thresh2 = '0;
    logic        level_irq2, flush2 = 1'b0, clr_ovf2 = 1'b0, ovf_sticky2;
    logic [15:0] ovf_cnt2;

    daq_sample_t q[$];
    logic [23:0] q2[$];
    logic [15:0] m_ovf = '0;
    logic        m_sticky = 1'b0;
    int          pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    daq_sample_fifo #(.DW(24), .DEPTH_LOG2(2), .DROP_ON_FULL(1'b1)) dut_drop (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .rd_cnt(rd_cnt), .thresh(thresh), .level_irq(level_irq),
        .flush(flush), .clr_ovf(clr_ovf), .overflow_cnt(ovf_cnt), .ovf_sticky(ovf_sticky)
    );

    daq_sample_fifo #(.DW(24), .DEPTH_LOG2(2), .DROP_ON_FULL(1'b0)) dut_stall (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
        .rd_cnt(rd_cnt2), .thresh(thresh2), .level_irq(level_irq2),
        .flush(flush2), .clr_ovf(clr_ovf2), .overflow_cnt(ovf_cnt2), .ovf_sticky(ovf_sticky2)
    );

    // One clock of the drop-mode instance: drive, score, advance, compare.
    task automatic step_drop(input bit do_push, input logic [23:0] d, input bit do_pop,
                             input bit do_flush, input bit do_clr);
        bit pop_m, full_m, drop_m, irq_m;
        s_tdata = d; s_tvalid = do_push; m_tready = do_pop; flush = do_flush; clr_ovf = do_clr;
        #1;
        full_m = (q.size() == 4);
        pop_m  = do_pop && (q.size() != 0) && !do_flush;
        if (pop_m) begin
            total_cnt++;
            if (m_tdata !== q[0]) $display("FAIL pop_data: got %h expected %h", m_tdata, q[0]);
            else pass_cnt++;
            void'(q.pop_front());
        end
        drop_m = do_push && full_m && !pop_m && !do_flush;
        if (do_flush) q.delete();
        else if (do_push && !drop_m) q.push_back(d);
        if (do_clr) begin
            m_ovf = drop_m ? 16'd1 : 16'd0;
            m_sticky = drop_m;
        end else if (drop_m) begin
            if (m_ovf != 16'hFFFF) m_ovf++;
            m_sticky = 1'b1;
        end
        @(negedge clk);
        s_tvalid = 1'b0; m_tready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        irq_m = (thresh != 0) && (q.size() >= int'(thresh));
        total_cnt++;
        if (rd_cnt !== 32'(q.size())) $display("FAIL rd_cnt: got %0d expected %0d", rd_cnt, q.size());
        else pass_cnt++;
        total_cnt++;
        if (m_tvalid !== (q.size() != 0)) $display("FAIL m_tvalid: got %b expected %b", m_tvalid, q.size() != 0);
        else pass_cnt++;
        if (q.size() != 0) begin
            total_cnt++;
            if (m_tdata !== q[0]) $display("FAIL head_data: got %h expected %h", m_tdata, q[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (ovf_cnt !== m_ovf) $display("FAIL overflow_cnt: got %0d expected %0d", ovf_cnt, m_ovf);
        else pass_cnt++;
        total_cnt++;
        if (ovf_sticky !== m_sticky) $display("FAIL ovf_sticky: got %b expected %b", ovf_sticky, m_sticky);
        else pass_cnt++;
        total_cnt++;
        if (level_irq !== irq_m) $display("FAIL level_irq: got %b expected %b", level_irq, irq_m);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({m_tvalid, level_irq, ovf_sticky} !== 3'b000 || rd_cnt !== 32'd0 || ovf_cnt !== 16'd0)
            $display("FAIL reset_outputs: got tvalid=%b irq=%b sticky=%b rd_cnt=%0d ovf=%0d expected all 0",
                     m_tvalid, level_irq, ovf_sticky, rd_cnt, ovf_cnt);
        else pass_cnt++;
        total_cnt++;
        if (s_tready !== 1'b1) $display("FAIL reset_tready_drop: got %b expected 1", s_tready);
        else pass_cnt++;
        total_cnt++;
        if (s_tready2 !== 1'b0) $display("FAIL reset_tready_stall: got %b expected 0", s_tready2);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (s_tready2 !== 1'b1) $display("FAIL release_tready_stall: got %b expected 1", s_tready2);
        else pass_cnt++;
        total_cnt++;
        if (s_tready !== 1'b1 || rd_cnt !== 32'd0) $display("FAIL release_drop: got tready=%b rd_cnt=%0d expected 1/0", s_tready, rd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_first_word();
        step_drop(1'b1, 24'h000123, 1'b0, 1'b0, 1'b0);
        step_drop(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) step_drop(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_drop(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 5; i <= 8; i++) step_drop(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h000009, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_drop(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_level_irq();
        thresh = 3'd3;
        for (int i = 1; i <= 3; i++) step_drop(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_drop(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        thresh = 3'd0;
        step_drop(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_clr();
        step_drop(1'b1, 24'h00000A, 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h00000B, 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h00000C, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step_drop(1'b1, 24'h800000 + 24'(i), 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h0000EE, 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h0000EF, 1'b0, 1'b0, 1'b1);
        step_drop(1'b1, 24'h0000F0, 1'b0, 1'b1, 1'b0);
        step_drop(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 4; i++) begin
            s_tdata2 = 24'(i); s_tvalid2 = 1'b1;
            @(negedge clk);
            q2.push_back(24'(i));
        end
        s_tdata2 = 24'h000005;
        total_cnt++;
        if (s_tready2 !== 1'b0 || rd_cnt2 !== 32'd4) $display("FAIL stall_full: got tready=%b rd_cnt=%0d expected 0/4", s_tready2, rd_cnt2);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rd_cnt2 !== 32'd4) $display("FAIL stall_hold: got %0d expected 4", rd_cnt2);
        else pass_cnt++;
        m_tready2 = 1'b1;
        total_cnt++;
        if (m_tdata2 !== q2[0]) $display("FAIL stall_pop_data: got %h expected %h", m_tdata2, q2[0]);
        else pass_cnt++;
        void'(q2.pop_front());
        @(negedge clk);
        m_tready2 = 1'b0;
        total_cnt++;
        if (rd_cnt2 !== 32'd3 || s_tready2 !== 1'b1) $display("FAIL stall_after_pop: got rd_cnt=%0d tready=%b expected 3/1", rd_cnt2, s_tready2);
        else pass_cnt++;
        @(negedge clk);
        q2.push_back(24'h000005);
        s_tvalid2 = 1'b0;
        total_cnt++;
        if (rd_cnt2 !== 32'd4) $display("FAIL stall_accept: got %0d expected 4", rd_cnt2);
        else pass_cnt++;
        while (q2.size() != 0) begin
            total_cnt++;
            if (m_tdata2 !== q2[0]) $display("FAIL stall_drain: got %h expected %h", m_tdata2, q2[0]);
            else pass_cnt++;
            void'(q2.pop_front());
            m_tready2 = 1'b1;
            @(negedge clk);
            m_tready2 = 1'b0;
        end
        total_cnt++;
        if (m_tvalid2 !== 1'b0 || rd_cnt2 !== 32'd0 || ovf_cnt2 !== 16'd0)
            $display("FAIL stall_empty: got tvalid=%b rd_cnt=%0d ovf=%0d expected 0/0/0", m_tvalid2, rd_cnt2, ovf_cnt2);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        step_drop(1'b1, 24'h000077, 1'b0, 1'b0, 1'b0);
        step_drop(1'b1, 24'h000078, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (m_tvalid !== 1'b0 || rd_cnt !== 32'd0) $display("FAIL mid_reset: got tvalid=%b rd_cnt=%0d expected 0/0", m_tvalid, rd_cnt);
        else pass_cnt++;
        q.delete(); m_ovf = '0; m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_drop(1'b1, 24'h000079, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_word();
        test_overflow();
        test_back_to_back();
        test_level_irq();
        test_flush_clr();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/daq_sample_fifo.md
Name: daq_sample_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) sample buffer on the LPDAQ acquisition path.
- Accepts signed ADC/filter samples on an AXI-stream slave port and presents the head word to the AXI4-lite readout interface on an AXI-stream master port.
- Publishes the 32-bit occupancy `rd_cnt` used by that interface to decide whether a read returns data.
- Counts and flags samples lost when the buffer is full, because the ADC path cannot be back-pressured.

Parameters:
- DW, 24: sample width in bits.
- DEPTH_LOG2, 8: log2 of the entry count (256 entries).
- DROP_ON_FULL, 1: 1 = upstream never stalls and samples are dropped when full; 0 = `s_axis_tready` deasserts when full.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DW  input sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  DW  head-of-FIFO sample.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  pop request from the readout interface.
- rd_cnt  out  32  stored-word count, zero-extended.
- thresh  in  DEPTH_LOG2+1  level-interrupt threshold.
- level_irq  out  1  registered flag: rd_cnt >= thresh and thresh != 0.
- flush  in  1  synchronous clear of contents.
- clr_ovf  in  1  clears overflow_cnt and ovf_sticky.
- overflow_cnt  out  16  saturating count of dropped samples.
- ovf_sticky  out  1  set on any drop.

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst_n` is asynchronous and active-low.
  - While rst_n=0, all of the following are 0: pointers, count, rd_cnt, m_axis_tvalid, level_irq, overflow_cnt, ovf_sticky.
  - m_axis_tdata is don't-care while m_axis_tvalid=0.
  - s_axis_tready resets to 1 when DROP_ON_FULL=1 and to 0 when DROP_ON_FULL=0; in the latter case it becomes 1 on the first cycle after reset release.
  - Reset mid-operation discards all contents.
- Storage and flags:
  - Storage is a 2^DEPTH_LOG2 register array with asynchronous read at rd_ptr.
  - Write pointer, read pointer and count are DEPTH_LOG2, DEPTH_LOG2 and DEPTH_LOG2+1 bits wide.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- Pop and push:
  - pop = m_axis_tvalid & m_axis_tready.
  - push = s_axis_tvalid & accept, where accept = !full | pop in drop mode, and accept = s_axis_tready = !full in stall mode.
  - In stall mode there is no same-cycle pass-through when full.
- Latency and visibility:
  - A sample pushed at edge N is visible after edge N: m_axis_tvalid=1, m_axis_tdata = that sample if the FIFO was empty, and rd_cnt incremented.
  - rd_cnt != 0 always coincides with m_axis_tvalid=1.
  - m_axis_tdata holds its value until a pop. The readout block latches data on its address handshake and pops later, so data must not change under it.
- Count update and simultaneous events:
  - Count changes +1 on push only, -1 on pop only, and is unchanged on push+pop.
  - On push+pop while empty, the pop is not possible because m_axis_tvalid=0, so only the push takes effect.
  - rd_cnt and level_irq are registered from the next-state count, so both have zero extra lag relative to m_axis_tvalid.
- Drops:
  - A drop occurs when s_axis_tvalid=1, the FIFO is full, there is no pop, and DROP_ON_FULL=1.
  - On a drop: the sample is discarded, ovf_sticky is set to 1, and overflow_cnt increments, saturating at 16'hFFFF.
  - DROP_ON_FULL=0 never drops.
- clr_ovf:
  - Clears overflow_cnt and ovf_sticky.
  - If a drop occurs in the same cycle as clr_ovf, the result is overflow_cnt=1 and ovf_sticky=1.
- flush:
  - Has priority over push and pop in the same cycle.
  - Pointers and count go to 0, and m_axis_tvalid=0 after the edge.
  - Any concurrent input sample is discarded and is not counted as a drop.
  - Overflow state is not affected by flush.
- level_irq:
  - Recomputed every cycle; it is a level, not a pulse.
  - thresh=0 disables it.

Decomposition:
- Package daq_pkg holds:
  - DAQ_SAMPLE_W=24.
  - DAQ_RDCNT_W=32.
  - DAQ_OVF_W=16.
  - Typedef daq_sample_t (logic signed [DAQ_SAMPLE_W-1:0]).
- Sub-module daq_fifo_mem: 1-write/async-read register array, parameterised by DW and DEPTH_LOG2.
- Pointers, count, flags and counters stay in the top module.

Test Plan (bench uses DEPTH_LOG2=2, i.e. depth 4):
- Reset release → all outputs 0 and s_axis_tready=1. Push 24'h000123 → after one edge m_axis_tvalid=1, m_axis_tdata=24'h000123, rd_cnt=1.
- Push 1,2,3,4 (m_axis_tready=0), then push 5 with DROP_ON_FULL=1 → rd_cnt=4, overflow_cnt=1, ovf_sticky=1. Pop 4 times → data 1,2,3,4, then m_axis_tvalid=0, rd_cnt=0.
- Full FIFO with push of 9 and pop in the same cycle → pop returns the head, rd_cnt stays 4, 9 is last out, no drop counted.
- DROP_ON_FULL=0 with 4 pushes → s_axis_tready=0. Fifth sample held with tvalid=1 → accepted one edge after a pop, rd_cnt returns to 4.
- thresh=3: pushes 1,2,3 → level_irq=1 after the third push; one pop → level_irq=0.
- With 2 words stored, assert flush together with a push → rd_cnt=0 and m_axis_tvalid=0 after the edge. Assert clr_ovf in a drop cycle → overflow_cnt=1.
